// File: rtl/frame_loader.sv
// Assembles a fixed-length order frame from a byte stream and hands it to the
// order-book engine through a request/acknowledge handshake on system_free.
module frame_loader #(
    parameter int FRAME_BYTES = 41,
    parameter int GAP_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_sof,
    output logic                     in_ready,
    input  logic                     system_free,
    output logic                     buffer_not_empty,
    output logic [8*FRAME_BYTES-1:0] ff_buffer,
    output logic                     busy,
    output logic [15:0]              frame_count,
    output logic [7:0]               drop_count
);

    localparam int IDX_W = $clog2(FRAME_BYTES + 1);
    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        READY,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t            state, next_state;
    logic [IDX_W-1:0]  idx, next_idx, wr_idx;
    logic [GAP_W-1:0]  gap, next_gap;
    logic              accept, wr_en, drop_inc, frame_inc;

    always_comb begin
        next_state = state;
        next_idx   = idx;
        next_gap   = gap;
        wr_idx     = idx;
        wr_en      = 1'b0;
        drop_inc   = 1'b0;
        frame_inc  = 1'b0;
        accept     = in_valid & in_ready;
        case (state)
            IDLE: begin
                if (accept && in_sof) begin
                    wr_en      = 1'b1;
                    wr_idx     = '0;
                    next_idx   = IDX_W'(1);
                    next_gap   = '0;
                    next_state = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en    = 1'b1;
                    next_gap = '0;
                    if (in_sof) begin
                        // A new start-of-frame abandons the partial frame and restarts it.
                        wr_idx   = '0;
                        next_idx = IDX_W'(1);
                        drop_inc = 1'b1;
                    end else if (idx == LAST_IDX) begin
                        next_idx   = '0;
                        next_state = READY;
                    end else begin
                        next_idx = idx + IDX_W'(1);
                    end
                end else if (gap == GAP_LAST) begin
                    next_gap   = '0;
                    next_idx   = '0;
                    drop_inc   = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_gap = gap + GAP_W'(1);
                end
            end
            READY: begin
                if (system_free) next_state = ISSUE;
            end
            ISSUE: begin
                if (!system_free) next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (system_free) begin
                    frame_inc  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            idx              <= '0;
            gap              <= '0;
            in_ready         <= 1'b1;
            busy             <= 1'b0;
            buffer_not_empty <= 1'b0;
            frame_count      <= '0;
            drop_count       <= '0;
            ff_buffer        <= '0;
        end else begin
            state            <= next_state;
            idx              <= next_idx;
            gap              <= next_gap;
            in_ready         <= (next_state == IDLE) || (next_state == FILL);
            busy             <= (next_state != IDLE);
            buffer_not_empty <= (next_state == ISSUE);
            if (frame_inc) frame_count <= frame_count + 16'd1;
            if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            for (int k = 0; k < FRAME_BYTES; k++) begin
                if (wr_en && wr_idx == IDX_W'(k)) ff_buffer[8*(FRAME_BYTES-k)-1 -: 8] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// Randomized scoreboard bench for frame_loader: a queue-based frame model predicts
// each assembled frame and the counters; a monitor checks frames as they are issued.
module tb_frame_loader;

    localparam int FB = 41;
    localparam int GT = 255;
    localparam int W  = 8 * FB;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_sof;
    logic         in_ready;
    logic         system_free;
    logic         buffer_not_empty;
    logic [W-1:0] ff_buffer;
    logic         busy;
    logic [15:0]  frame_count;
    logic [7:0]   drop_count;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] exp_frames[$];
    logic [7:0]   cur[$];
    int           exp_drop = 0;
    int           exp_done = 0;
    logic [W-1:0] last_frame = '0;

    always #5 clk = ~clk;

    frame_loader #(.FRAME_BYTES(FB), .GAP_TIMEOUT(GT)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_sof           (in_sof),
        .in_ready         (in_ready),
        .system_free      (system_free),
        .buffer_not_empty (buffer_not_empty),
        .ff_buffer        (ff_buffer),
        .busy             (busy),
        .frame_count      (frame_count),
        .drop_count       (drop_count)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkFrame(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic void modelDrop();
        if (exp_drop < 255) exp_drop++;
    endfunction

    // A frame is the FB bytes following the most recent start-of-frame byte.
    function automatic bit modelAccept(input logic [7:0] d, input bit sof);
        logic [W-1:0] f;
        if (sof) begin
            if (cur.size() != 0) modelDrop();
            cur.delete();
            cur.push_back(d);
        end else if (cur.size() != 0) begin
            cur.push_back(d);
        end
        if (cur.size() == FB) begin
            f = last_frame;
            for (int k = 0; k < FB; k++) f[8*(FB-k)-1 -: 8] = cur[k];
            exp_frames.push_back(f);
            last_frame = f;
            cur.delete();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void modelTimeout();
        if (cur.size() != 0) modelDrop();
        cur.delete();
    endfunction

    function automatic void modelReset();
        cur.delete();
        exp_frames.delete();
        exp_drop   = 0;
        exp_done   = 0;
        last_frame = '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit sof, output bit done);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        checkOutput("in_ready_for_byte", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        done = modelAccept(d, sof);
    endtask

    task automatic sendBytes(input int n, input bit gaps);
        bit done;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) idle($urandom_range(0, 3));
            applyStimulus(8'($urandom), i == 0, done);
        end
    endtask

    // Plays the engine side: optional hold-off, request, hold, release, and return.
    task automatic engineServe(input int pre, input int hold, input int away);
        if (pre > 0) begin
            system_free = 1'b0;
            repeat (pre) begin
                step();
                checkOutput("bnf_held_off", 32'(buffer_not_empty), 0);
                checkOutput("ready_held_off", 32'(in_ready), 0);
            end
            system_free = 1'b1;
        end
        step();
        checkOutput("bnf_raised", 32'(buffer_not_empty), 1);
        repeat (hold) begin
            step();
            checkOutput("bnf_held", 32'(buffer_not_empty), 1);
        end
        system_free = 1'b0;
        step();
        checkOutput("bnf_fall", 32'(buffer_not_empty), 0);
        checkOutput("busy_wait_done", 32'(busy), 1);
        repeat (away) begin
            step();
            checkOutput("ready_wait_done", 32'(in_ready), 0);
            checkOutput("frame_count_before_return", 32'(frame_count), exp_done % 65536);
        end
        system_free = 1'b1;
        step();
        exp_done++;
        checkOutput("frame_count", 32'(frame_count), exp_done % 65536);
        checkOutput("ready_after_return", 32'(in_ready), 1);
        checkOutput("busy_after_return", 32'(busy), 0);
        checkOutput("drop_count", 32'(drop_count), exp_drop);
    endtask

    // Monitor: every issued frame is popped from the scoreboard and must stay stable while requested.
    initial begin
        logic         prev = 1'b0;
        logic [W-1:0] cur_exp = '0;
        forever begin
            @(negedge clk);
            if (resetn && buffer_not_empty) begin
                if (!prev) begin
                    checkOutput("frame_pending", 32'(exp_frames.size() != 0), 1);
                    if (exp_frames.size() != 0) cur_exp = exp_frames.pop_front();
                end
                checkFrame("ff_buffer_issue", ff_buffer, cur_exp);
            end
            prev = buffer_not_empty;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit done;
        int kind;
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_sof      = 1'b0;
        system_free = 1'b0;
        #12;
        checkOutput("reset_bnf", 32'(buffer_not_empty), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_frame_count", 32'(frame_count), 0);
        checkOutput("reset_drop_count", 32'(drop_count), 0);
        checkFrame("reset_ff_buffer", ff_buffer, '0);
        #10 resetn = 1'b1;
        step();
        checkOutput("ready_after_reset", 32'(in_ready), 1);
        checkOutput("busy_after_reset", 32'(busy), 0);

        // Non-start byte in IDLE is discarded.
        applyStimulus(8'h33, 1'b0, done);
        checkOutput("idle_discard_busy", 32'(busy), 0);
        checkOutput("idle_discard_drop", 32'(drop_count), exp_drop);

        // Counting frame, engine already free: minimum latency, then 3-cycle hold and 20-cycle return.
        system_free = 1'b1;
        for (int i = 0; i < FB; i++) applyStimulus(8'(i), i == 0, done);
        checkOutput("bnf_at_last_accept", 32'(buffer_not_empty), 0);
        checkOutput("ready_at_last_accept", 32'(in_ready), 0);
        checkOutput("busy_at_last_accept", 32'(busy), 1);
        engineServe(0, 3, 20);
        checkOutput("first_byte", 32'(ff_buffer[W-1 -: 8]), 32'h00);
        checkOutput("last_byte", 32'(ff_buffer[7:0]), 32'h28);

        // Engine busy for 10 cycles while the source holds a byte against in_ready=0.
        system_free = 1'b0;
        sendBytes(FB, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_sof   = 1'b0;
        engineServe(10, 2, 5);
        step();
        in_valid = 1'b0;
        done = modelAccept(8'h55, 1'b0);
        checkOutput("held_byte_discarded_busy", 32'(busy), 0);
        checkOutput("held_byte_drop", 32'(drop_count), exp_drop);
        checkFrame("frame_retained", ff_buffer, last_frame);

        // Restart mid-frame with a start byte of 0xAA.
        system_free = 1'b1;
        sendBytes(20, 1'b0);
        applyStimulus(8'hAA, 1'b1, done);
        for (int i = 0; i < FB - 1; i++) applyStimulus(8'($urandom), 1'b0, done);
        checkOutput("restart_drop", 32'(drop_count), 1);
        engineServe(0, 1, 2);
        checkOutput("restart_first_byte", 32'(ff_buffer[W-1 -: 8]), 32'hAA);

        // Gap timeout after 10 bytes.
        sendBytes(10, 1'b0);
        idle(GT);
        modelTimeout();
        checkOutput("timeout_busy", 32'(busy), 0);
        checkOutput("timeout_ready", 32'(in_ready), 1);
        checkOutput("timeout_drop", 32'(drop_count), exp_drop);

        // Randomized traffic: full frames, restarted frames, and timed-out fragments.
        repeat (25) begin
            kind = $urandom_range(0, 3);
            if (kind == 3) begin
                sendBytes($urandom_range(1, FB - 1), 1'b1);
                idle(GT);
                modelTimeout();
                checkOutput("rand_timeout_busy", 32'(busy), 0);
                checkOutput("rand_timeout_drop", 32'(drop_count), exp_drop);
            end else begin
                system_free = 1'($urandom_range(0, 1));
                if (kind == 2) sendBytes($urandom_range(1, FB - 1), 1'b1);
                sendBytes(FB, 1'b1);
                engineServe(system_free ? 0 : $urandom_range(1, 6),
                            $urandom_range(0, 4), $urandom_range(0, 6));
            end
        end

        // Repeated start bytes abort frames until the drop counter saturates.
        for (int i = 0; i < 300; i++) applyStimulus(8'($urandom), 1'b1, done);
        checkOutput("drop_saturated", 32'(drop_count), exp_drop);
        idle(GT);
        modelTimeout();
        checkOutput("drop_saturated_after_timeout", 32'(drop_count), 255);
        checkOutput("saturation_busy", 32'(busy), 0);

        // Reset while the frame is being requested.
        system_free = 1'b1;
        sendBytes(FB, 1'b0);
        step();
        checkOutput("issue_before_reset", 32'(buffer_not_empty), 1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_reset_bnf", 32'(buffer_not_empty), 0);
        checkOutput("async_reset_busy", 32'(busy), 0);
        checkOutput("async_reset_frame_count", 32'(frame_count), 0);
        checkOutput("async_reset_drop_count", 32'(drop_count), 0);
        checkFrame("async_reset_ff_buffer", ff_buffer, '0);
        modelReset();
        #3 resetn = 1'b1;
        step();
        checkOutput("ready_after_midreset", 32'(in_ready), 1);

        // Recovery frame after the reset.
        sendBytes(FB, 1'b1);
        engineServe(0, 2, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
